// File: rtl/lfsr_way_sel_if.sv
// Replacement request / victim result bundle for lfsr_way_sel.
// Master issues requests and consumes results; slave is the selector.
interface lfsr_way_sel_if #(
  parameter int unsigned NR_WAYS = 8
) ();

  localparam int unsigned LOG_WAYS = $clog2(NR_WAYS);

  logic                req_valid;
  logic                req_ready;
  logic [NR_WAYS-1:0]  valid_ways;
  logic [NR_WAYS-1:0]  lock_ways;

  logic                way_valid;
  logic                way_ready;
  logic [NR_WAYS-1:0]  way;
  logic [LOG_WAYS-1:0] way_idx;
  logic                way_none;

  modport master (
    output req_valid,
    output valid_ways,
    output lock_ways,
    output way_ready,
    input  req_ready,
    input  way_valid,
    input  way,
    input  way_idx,
    input  way_none
  );

  modport slave (
    input  req_valid,
    input  valid_ways,
    input  lock_ways,
    input  way_ready,
    output req_ready,
    output way_valid,
    output way,
    output way_idx,
    output way_none
  );

endinterface

// File: rtl/lfsr_way_sel.sv
// Victim-way selector: lowest free way, else random unlocked way from LFSR.
// Ports: clk_i, rst_ni (sync, active-low), bus (slave), rnd_i, lfsr_en_o.
module lfsr_way_sel #(
  parameter int unsigned NR_WAYS    = 8,
  parameter int unsigned LFSR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lfsr_way_sel_if.slave         bus,
  input  logic [LFSR_WIDTH-1:0] rnd_i,
  output logic                  lfsr_en_o
);

  localparam int unsigned LOG_WAYS = $clog2(NR_WAYS);
  localparam int unsigned CNT_W    = LOG_WAYS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e              state_q;
  logic [NR_WAYS-1:0]  vld_q;
  logic [NR_WAYS-1:0]  lck_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                way_valid_q;
  logic [NR_WAYS-1:0]  way_q;
  logic [LOG_WAYS-1:0] way_idx_q;
  logic                way_none_q;

  function automatic logic [LOG_WAYS-1:0] lsb_idx(
    input logic [NR_WAYS-1:0] m
  );
    lsb_idx = '0;
    for (int i = NR_WAYS - 1; i >= 0; i--) begin
      if (m[i]) lsb_idx = LOG_WAYS'(i);
    end
  endfunction

  logic [NR_WAYS-1:0]  free;
  logic [LOG_WAYS-1:0] cand;
  logic                has_free;
  logic                all_lck;
  logic                rand_path;
  logic                cand_ok;
  logic                last_try;

  assign free      = ~vld_q & ~lck_q;
  assign cand      = rnd_i[LOG_WAYS-1:0];
  assign has_free  = |free;
  assign all_lck   = &lck_q;
  assign rand_path = ~has_free & ~all_lck;
  assign cand_ok   = ~lck_q[cand];
  assign last_try  = (cnt_q == CNT_W'(NR_WAYS - 1));

  // The LFSR only steps when a random candidate is actually drawn.
  assign lfsr_en_o = (state_q == SCAN) & rand_path;

  generate
    if (LFSR_WIDTH > LOG_WAYS) begin : g_rnd_hi
      logic unused_rnd_hi;
      assign unused_rnd_hi = ^rnd_i[LFSR_WIDTH-1:LOG_WAYS];
    end
  endgenerate

  logic                sel_done;
  logic                sel_none;
  logic [LOG_WAYS-1:0] sel_idx;
  logic [NR_WAYS-1:0]  sel_oh;

  always_comb begin
    sel_done = 1'b0;
    sel_none = 1'b0;
    sel_idx  = '0;
    unique case (1'b1)
      has_free: begin
        sel_done = 1'b1;
        sel_idx  = lsb_idx(free);
      end
      (~has_free & all_lck): begin
        sel_done = 1'b1;
        sel_none = 1'b1;
      end
      (rand_path & cand_ok): begin
        sel_done = 1'b1;
        sel_idx  = cand;
      end
      // Out of tries: fall back to the lowest unlocked way.
      (rand_path & ~cand_ok & last_try): begin
        sel_done = 1'b1;
        sel_idx  = lsb_idx(~lck_q);
      end
      default: begin
        sel_done = 1'b0;
      end
    endcase
  end

  assign sel_oh = sel_none ? '0 : (NR_WAYS'(1) << sel_idx);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      lck_q       <= '0;
      cnt_q       <= '0;
      way_valid_q <= 1'b0;
      way_q       <= '0;
      way_idx_q   <= '0;
      way_none_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            vld_q   <= bus.valid_ways;
            lck_q   <= bus.lock_ways;
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (sel_done) begin
            way_valid_q <= 1'b1;
            way_q       <= sel_oh;
            way_idx_q   <= sel_idx;
            way_none_q  <= sel_none;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        OUT: begin
          if (bus.way_ready) begin
            way_valid_q <= 1'b0;
            way_q       <= '0;
            way_idx_q   <= '0;
            way_none_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = rst_ni & (state_q == IDLE);
  assign bus.way_valid = way_valid_q;
  assign bus.way       = way_q;
  assign bus.way_idx   = way_idx_q;
  assign bus.way_none  = way_none_q;

endmodule
